interval_meter: RTL and testbench

- Measuring counterpart of the delay timer. The timer turns a programmed count into an elapsed-time event; this block turns a start/stop event pair into a cycle count.
- Counts clk edges between a sampled start and a sampled stop.
- Presents the result with a valid/ack handshake and a saturation flag.
- Used to profile memory/cache access latency and to cross-check timer programming in the lab CPU datapath.

---
 rtl/interval_pkg.sv | 23 ++
 rtl/sat_counter.sv | 44 ++++
 rtl/interval_meter.sv | 127 ++++++++++++
 tb/tb_interval_meter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/interval_pkg.sv
// -----------------------------------------------------------------------------
// interval_pkg
// Shared definitions for the interval meter:
//   - state_t      : measurement FSM states (IDLE, COUNTING, DONE)
//   - DEFAULT_WIDTH: default count/result width
//   - max_count()  : largest value representable in a given width (2^w - 1)
// -----------------------------------------------------------------------------
package interval_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    DONE     = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Saturation point of a WIDTH-bit counter. Valid for widths up to 31.
  function automatic int unsigned max_count(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage : interval_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that loads the value 1 on request and otherwise increments,
// holding at its maximum value instead of wrapping to zero.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high; clears count
//   load_one in   load count with 1 (takes priority over inc)
//   inc      in   increment by one unless already at max
//   count    out  current count
//   at_max   out  count equals 2^WIDTH-1
// -----------------------------------------------------------------------------
module sat_counter
  import interval_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_one,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(max_count(WIDTH));
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  assign at_max = (count == MAX_VAL);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load_one) begin
      count <= ONE;
    end else if (inc && !at_max) begin
      count <= count + ONE;
    end
  end

endmodule : sat_counter

// File: rtl/interval_meter.sv
// -----------------------------------------------------------------------------
// interval_meter
// Measures the number of clk edges between a sampled start and a sampled
// stop. Start at edge N and stop at edge N+k yields value=k (k>=1). Intervals
// longer than 2^WIDTH-1 cycles saturate the result and raise overflow. The
// result is offered with a valid/ack handshake and held until acknowledged.
//
// Ports:
//   clk      in   system clock; all inputs sampled on posedge
//   reset    in   asynchronous, active-high; clears all state immediately
//   start    in   begin or restart a measurement
//   stop     in   end the current measurement
//   ack      in   consumer has taken the result
//   value    out  measured interval in cycles (meaningful while valid=1)
//   valid    out  result available; held until ack
//   overflow out  interval exceeded 2^WIDTH-1 cycles (meaningful with valid)
//   busy     out  measurement in progress
// -----------------------------------------------------------------------------
module interval_meter
  import interval_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             ack,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             load_one;
  logic             inc;

  // Counter control. A (re)start loads 1 so that a stop on the very next
  // edge reports an interval of one cycle. While counting, a sampled start or
  // stop freezes normal incrementing for that edge.
  // NOTE: every signal driven here gets a default first so no path through
  // the case leaves it unassigned, which would infer a latch.
  always_comb begin
    load_one = 1'b0;
    inc      = 1'b0;
    unique case (state)
      IDLE:     load_one = start;
      COUNTING: begin
        load_one = start;
        inc      = !start && !stop;
      end
      DONE:     load_one = ack && start;
      default:  ;
    endcase
  end

  sat_counter #(.WIDTH(WIDTH)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load_one (load_one),
    .inc      (inc),
    .count    (count),
    .at_max   (at_max)
  );

  // FSM plus result/flag registers. busy is set only on entry to COUNTING and
  // cleared on the stop that sets valid, so the two are never high together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      value    <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= COUNTING;
            overflow <= 1'b0;
            busy     <= 1'b1;
          end
        end

        COUNTING: begin
          if (start) begin
            // Restart wins over a simultaneous stop.
            overflow <= 1'b0;
          end else if (stop) begin
            // overflow deliberately keeps its current value here.
            value <= count;
            valid <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else if (at_max) begin
            // Counter holds at max; the extra cycle is recorded as overflow.
            overflow <= 1'b1;
          end
        end

        DONE: begin
          // Without ack the result is held; a lone start cannot overwrite it.
          if (ack) begin
            valid    <= 1'b0;
            overflow <= 1'b0;
            if (start) begin
              state <= COUNTING;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : interval_meter

// File: tb/tb_interval_meter.sv
// -----------------------------------------------------------------------------
// tb_interval_meter
// Self-checking bench for interval_meter (WIDTH=4). Expected results are
// pushed to a scoreboard queue when stop is driven and popped when the DUT
// presents valid. Observed outputs are packed as {valid, busy, overflow, value}.
// -----------------------------------------------------------------------------
module tb_interval_meter;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] v;
    logic         ov;
  } res_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic         ack;
  logic [W-1:0] value;
  logic         valid;
  logic         overflow;
  logic         busy;

  int passed = 0;
  int total  = 0;
  res_t sb[$];

  interval_meter #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .ack      (ack),
    .value    (value),
    .valid    (valid),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Observed output bundle: {valid, busy, overflow, value}.
  wire [W+2:0] obs = {valid, busy, overflow, value};

  function automatic logic [W+2:0] pack(input logic vl, input logic bs,
                                        input logic ov, input logic [W-1:0] v);
    return {vl, bs, ov, v};
  endfunction

  // Reference model of the measured result for an interval of k cycles.
  function automatic res_t model(input int k);
    res_t r;
    r.v  = (k > 15) ? W'(15) : W'(k);
    r.ov = (k > 15);
    return r;
  endfunction

  // Advance past one posedge; inputs set afterwards are sampled next edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  // Start, wait, stop so that stop is sampled k edges after start.
  task automatic measure(input int k);
    pulse_start();
    step(k - 1);
    sb.push_back(model(k));
    pulse_stop();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; ack = 1'b0;
    step(2);
    total++;
    if (obs !== pack(0, 0, 0, 0))
      $display("FAIL reset_state: got %b expected %b", obs, pack(0, 0, 0, 0));
    else passed++;
    #2 reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    res_t e;
    measure(5);
    e = sb.pop_front();
    total++;
    if (obs !== pack(1, 0, e.ov, e.v))
      $display("FAIL basic_k5: got %b expected %b", obs, pack(1, 0, e.ov, e.v));
    else passed++;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (obs !== pack(1, 0, 0, 5))
        $display("FAIL basic_hold%0d: got %b expected %b", i, obs, pack(1, 0, 0, 5));
      else passed++;
    end
    pulse_ack();
    total++;
    if (obs !== pack(0, 0, 0, 5))
      $display("FAIL basic_ack: got %b expected %b", obs, pack(0, 0, 0, 5));
    else passed++;
  endtask

  task automatic test_boundary();
    res_t e;
    foreach (sb[i]) ;
    measure(15);
    e = sb.pop_front();
    total++;
    if (obs !== pack(1, 0, e.ov, e.v))
      $display("FAIL bound_k15: got %b expected %b", obs, pack(1, 0, e.ov, e.v));
    else passed++;
    pulse_ack();
    measure(20);
    e = sb.pop_front();
    total++;
    if (obs !== pack(1, 0, e.ov, e.v))
      $display("FAIL bound_k20: got %b expected %b", obs, pack(1, 0, e.ov, e.v));
    else passed++;
    pulse_ack();
    total++;
    if (obs !== pack(0, 0, 0, 15))
      $display("FAIL bound_ack_clears_ovf: got %b expected %b", obs, pack(0, 0, 0, 15));
    else passed++;
  endtask

  task automatic test_restart();
    res_t e;
    pulse_start();
    step(2);
    pulse_start();              // restart 3 edges after the first start
    step(3);
    sb.push_back(model(4));
    pulse_stop();
    e = sb.pop_front();
    total++;
    if (obs !== pack(1, 0, e.ov, e.v))
      $display("FAIL restart_k4: got %b expected %b", obs, pack(1, 0, e.ov, e.v));
    else passed++;
    pulse_ack();
    // start and stop on the same edge while counting: restart wins
    pulse_start();
    step(1);
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    total++;
    if ({valid, busy} !== 2'b01)
      $display("FAIL restart_start_stop: got valid,busy=%b expected 01", {valid, busy});
    else passed++;
    step(1);
    sb.push_back(model(2));
    pulse_stop();
    e = sb.pop_front();
    total++;
    if (obs !== pack(1, 0, e.ov, e.v))
      $display("FAIL restart_after_tie: got %b expected %b", obs, pack(1, 0, e.ov, e.v));
    else passed++;
    pulse_ack();
  endtask

  task automatic test_handshake();
    res_t e;
    measure(6);
    e = sb.pop_front();
    total++;
    if (obs !== pack(1, 0, e.ov, e.v))
      $display("FAIL hs_k6: got %b expected %b", obs, pack(1, 0, e.ov, e.v));
    else passed++;
    pulse_start();              // no ack: must be ignored
    step(2);
    total++;
    if (obs !== pack(1, 0, 0, 6))
      $display("FAIL hs_start_no_ack: got %b expected %b", obs, pack(1, 0, 0, 6));
    else passed++;
    start = 1'b1; ack = 1'b1; step(); start = 1'b0; ack = 1'b0;
    total++;
    if ({valid, busy} !== 2'b01)
      $display("FAIL hs_start_ack: got valid,busy=%b expected 01", {valid, busy});
    else passed++;
    step(1);
    sb.push_back(model(2));
    pulse_stop();
    e = sb.pop_front();
    total++;
    if (obs !== pack(1, 0, e.ov, e.v))
      $display("FAIL hs_k2: got %b expected %b", obs, pack(1, 0, e.ov, e.v));
    else passed++;
    pulse_ack();
  endtask

  task automatic test_async_reset();
    pulse_start();
    step(4);
    total++;
    if (busy !== 1'b1)
      $display("FAIL arst_busy_before: got %b expected 1", busy);
    else passed++;
    #2 reset = 1'b1;            // between edges
    #1;
    total++;
    if (obs !== pack(0, 0, 0, 0))
      $display("FAIL arst_immediate: got %b expected %b", obs, pack(0, 0, 0, 0));
    else passed++;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    pulse_stop();
    step(1);
    total++;
    if (obs !== pack(0, 0, 0, 0))
      $display("FAIL arst_stop_ignored: got %b expected %b", obs, pack(0, 0, 0, 0));
    else passed++;
  endtask

  task automatic test_spurious();
    pulse_stop();
    pulse_ack();
    stop = 1'b1; ack = 1'b1; step(); stop = 1'b0; ack = 1'b0;
    step(1);
    total++;
    if (obs !== pack(0, 0, 0, 0))
      $display("FAIL spurious_idle: got %b expected %b", obs, pack(0, 0, 0, 0));
    else passed++;
    // IDLE still responds to a real measurement afterwards
    measure(3);
    total++;
    if (sb.size() != 1)
      $display("FAIL spurious_sb: got %0d entries expected 1", sb.size());
    else begin
      res_t e = sb.pop_front();
      if (obs !== pack(1, 0, e.ov, e.v))
        $display("FAIL spurious_k3: got %b expected %b", obs, pack(1, 0, e.ov, e.v));
      else passed++;
    end
    pulse_ack();
    total++;
    if (sb.size() != 0)
      $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
    else passed++;
  endtask

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_restart();
    test_handshake();
    test_async_reset();
    test_spurious();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_interval_meter
